// File: rtl/ad9854_pkg.sv
// Shared types and constants for the AD9854 sweep controller.
// Optional build macro used by the controller: SWEEP_PINGPONG_EN.
package ad9854_pkg;

    localparam int FTW_W   = 48;
    localparam int DWELL_W = 32;

    localparam logic [FTW_W-1:0] RESET_FTW = 48'd1_407_374_883_553;
    // Tuning word for 1 MHz at the board's reference clock.
    localparam logic [FTW_W-1:0] FTW_1MHZ  = 48'd938_249_922_369;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/ad9854_dwell_timer.sv
// Loadable dwell down-counter; done_o is high in the last cycle of a dwell.
// A requested length of 0 is stretched to 1 so every point dwells at least one cycle.
module ad9854_dwell_timer #(
    parameter int DWELL_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               abort_i,
    input  logic [DWELL_W-1:0] len_i,
    output logic               done_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (len_i == '0) ? DWELL_W'(1) : len_i;
        end else if (abort_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/ad9854_sweep_ctrl.sv
// Frequency tuning word source for the AD9854 bus writer: static word or stepped sweep.
// Define SWEEP_PINGPONG_EN for a triangle sweep instead of the default sawtooth.
module ad9854_sweep_ctrl #(
    parameter int                 FTW_W     = ad9854_pkg::FTW_W,
    parameter int                 DWELL_W   = ad9854_pkg::DWELL_W,
    parameter logic [FTW_W-1:0]   RESET_FTW = ad9854_pkg::RESET_FTW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  restart,
    input  logic                  step_req,
    input  logic [FTW_W-1:0]      start_ftw,
    input  logic [FTW_W-1:0]      stop_ftw,
    input  logic [FTW_W-1:0]      step_ftw,
    input  logic [DWELL_W-1:0]    dwell_cyc,
    output logic [FTW_W-1:0]      ftw,
    output logic                  ftw_valid,
    input  logic                  ftw_ready,
    output logic                  busy,
    output logic                  wrap,
    output ad9854_pkg::state_t    dbg_state
);

    import ad9854_pkg::*;

    // Handshake: a word moves on any cycle with ftw_valid & ftw_ready; once
    // ftw_valid is raised, ftw holds and ftw_valid stays high until that cycle.

    state_t             state_q, state_d;
    logic [FTW_W-1:0]   cur_q, cur_d;
    logic [FTW_W-1:0]   last_q, last_d;
    logic               last_valid_q, last_valid_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic               ftw_valid_q, ftw_valid_d;
    logic               wrap_q, wrap_d;
    logic               pend_q, pend_d;

    logic               xfer;
    logic               tmr_load, tmr_abort, tmr_done;
    logic [FTW_W:0]     sum_w;
    logic [FTW_W-1:0]   next_ftw;
    logic               next_wrap;

`ifdef SWEEP_PINGPONG_EN
    logic               dir_q, dir_d;
    logic               next_dir;
    logic [FTW_W:0]     diff_w;
`endif

    assign xfer  = ftw_valid_q & ftw_ready;
    assign sum_w = {1'b0, cur_q} + {1'b0, step_ftw};

`ifdef SWEEP_PINGPONG_EN
    assign diff_w = {1'b0, cur_q} - {1'b0, step_ftw};

    // dir_q = 0 climbs toward stop_ftw, 1 descends toward start_ftw.
    always_comb begin
        next_ftw  = sum_w[FTW_W-1:0];
        next_wrap = 1'b0;
        next_dir  = dir_q;
        if (!dir_q) begin
            if (sum_w[FTW_W] || (sum_w[FTW_W-1:0] > stop_ftw)) begin
                next_dir = 1'b1;
                if (diff_w[FTW_W] || (diff_w[FTW_W-1:0] < start_ftw)) begin
                    next_ftw = start_ftw;
                end else begin
                    next_ftw = diff_w[FTW_W-1:0];
                end
            end
        end else begin
            if (diff_w[FTW_W] || (diff_w[FTW_W-1:0] < start_ftw)) begin
                next_dir  = 1'b0;
                next_wrap = 1'b1;
            end else begin
                next_ftw = diff_w[FTW_W-1:0];
            end
        end
    end
`else
    always_comb begin
        next_ftw  = sum_w[FTW_W-1:0];
        next_wrap = 1'b0;
        if (sum_w[FTW_W] || (sum_w[FTW_W-1:0] > stop_ftw)) begin
            next_ftw  = start_ftw;
            next_wrap = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        ftw_d        = ftw_q;
        ftw_valid_d  = ftw_valid_q;
        wrap_d       = 1'b0;
        pend_d       = pend_q;
        tmr_load     = 1'b0;
        tmr_abort    = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        dir_d        = dir_q;
`endif
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (run || !last_valid_q || (start_ftw != last_q)) begin
                    cur_d   = start_ftw;
                    state_d = ISSUE;
`ifdef SWEEP_PINGPONG_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (!ftw_valid_q) begin
                    // Word not yet offered, so a restart can still replace it.
                    ftw_valid_d = 1'b1;
                    ftw_d       = restart ? start_ftw : cur_q;
                    cur_d       = restart ? start_ftw : cur_q;
`ifdef SWEEP_PINGPONG_EN
                    if (restart) dir_d = 1'b0;
`endif
                end else begin
                    if (restart) pend_d = 1'b1;
                    if (xfer) begin
                        ftw_valid_d  = 1'b0;
                        last_d       = ftw_q;
                        last_valid_d = 1'b1;
                        pend_d       = 1'b0;
                        if (!run) begin
                            state_d = IDLE;
                        end else if (pend_q || restart) begin
                            cur_d   = start_ftw;
                            state_d = ISSUE;
`ifdef SWEEP_PINGPONG_EN
                            dir_d   = 1'b0;
`endif
                        end else begin
                            tmr_load = 1'b1;
                            state_d  = DWELL;
                        end
                    end
                end
            end
            DWELL: begin
                if (!run) begin
                    tmr_abort = 1'b1;
                    state_d   = IDLE;
                end else if (restart) begin
                    tmr_abort = 1'b1;
                    cur_d     = start_ftw;
                    state_d   = ISSUE;
`ifdef SWEEP_PINGPONG_EN
                    dir_d     = 1'b0;
`endif
                end else if (step_req || tmr_done) begin
                    tmr_abort = 1'b1;
                    cur_d     = next_ftw;
                    wrap_d    = next_wrap;
                    state_d   = ISSUE;
`ifdef SWEEP_PINGPONG_EN
                    dir_d     = next_dir;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= RESET_FTW;
            last_q       <= RESET_FTW;
            last_valid_q <= 1'b0;
            ftw_q        <= RESET_FTW;
            ftw_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            ftw_q        <= ftw_d;
            ftw_valid_q  <= ftw_valid_d;
            wrap_q       <= wrap_d;
            pend_q       <= pend_d;
        end
    end

`ifdef SWEEP_PINGPONG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    ad9854_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (tmr_load),
        .abort_i (tmr_abort),
        .len_i   (dwell_cyc),
        .done_o  (tmr_done)
    );

    assign ftw       = ftw_q;
    assign ftw_valid = ftw_valid_q;
    assign busy      = (state_q != IDLE);
    assign wrap      = wrap_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ad9854_sweep_ctrl.sv
// Self-checking bench for ad9854_sweep_ctrl: static issue, back-pressure, sweep tables,
// restart/step_req corners and asynchronous reset. Honours SWEEP_PINGPONG_EN.
module tb_ad9854_sweep_ctrl;

    import ad9854_pkg::*;

    localparam logic [47:0] FTW_5MHZ = 48'd4_691_249_611_844;
    localparam logic [47:0] S_OVF    = 48'hFFFF_FFFF_FFE2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic        step_req = 1'b0;
    logic        ftw_ready = 1'b0;
    logic [47:0] start_ftw = '0;
    logic [47:0] stop_ftw = '0;
    logic [47:0] step_ftw = '0;
    logic [31:0] dwell_cyc = '0;
    logic [47:0] ftw;
    logic        ftw_valid, busy, wrap;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [47:0] rec_ftw_q[$];
    logic        rec_wrap_q[$];
    int          rec_dwell_q[$];
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    ad9854_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .restart   (restart),
        .step_req  (step_req),
        .start_ftw (start_ftw),
        .stop_ftw  (stop_ftw),
        .step_ftw  (step_ftw),
        .dwell_cyc (dwell_cyc),
        .ftw       (ftw),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .busy      (busy),
        .wrap      (wrap),
        .dbg_state (dbg_state)
    );

    // Transfer monitor: logs each accepted word, whether a wrap preceded it,
    // and how many DWELL cycles elapsed since the previous transfer.
    int   dw_cnt;
    logic wflag;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_cnt <= 0;
            wflag  <= 1'b0;
        end else begin
            if (dbg_state == DWELL) dw_cnt <= dw_cnt + 1;
            if (wrap) wflag <= 1'b1;
            if (ftw_valid && ftw_ready) begin
                rec_ftw_q.push_back(ftw);
                rec_wrap_q.push_back(wflag | wrap);
                rec_dwell_q.push_back(dw_cnt);
                dw_cnt <= 0;
                wflag  <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [47:0]      start;
        logic [47:0]      step;
        logic [47:0]      stop;
        logic [31:0]      dwell;
        logic [5:0][47:0] words;
        logic [5:0]       wraps;
        int               dwell_exp;
    } vec_t;

    function automatic vec_t mk(input logic [47:0] st, input logic [47:0] sp, input logic [47:0] so,
                                input logic [31:0] dw, input int dwe, input logic [5:0] wr,
                                input logic [47:0] w0, input logic [47:0] w1, input logic [47:0] w2,
                                input logic [47:0] w3, input logic [47:0] w4, input logic [47:0] w5);
        vec_t v;
        v.start = st; v.step = sp; v.stop = so; v.dwell = dw; v.dwell_exp = dwe; v.wraps = wr;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
        v.words[3] = w3; v.words[4] = w4; v.words[5] = w5;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_recs(input int n, input int budget);
        int c = 0;
        while (rec_ftw_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check("record_count", 64'(rec_ftw_q.size() >= n), 64'd1);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        rec_ftw_q.delete();
        rec_wrap_q.delete();
        rec_dwell_q.delete();
        tick(2);
    endtask

    task automatic release_reset();
        rst = 1'b0;
    endtask

    task automatic pulse(input bit rs, input bit sr);
        restart  = rs;
        step_req = sr;
        tick(1);
        restart  = 1'b0;
        step_req = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int r);
        hold_reset();
        start_ftw = v.start;
        step_ftw  = v.step;
        stop_ftw  = v.stop;
        dwell_cyc = v.dwell;
        ftw_ready = 1'b1;
        run       = 1'b1;
        release_reset();
        wait_recs(6, 300);
        for (int k = 0; k < 6; k++) begin
            if (k < rec_ftw_q.size()) begin
                check($sformatf("row%0d_word%0d", r, k), 64'(rec_ftw_q[k]), 64'(v.words[k]));
                check($sformatf("row%0d_wrap%0d", r, k), 64'(rec_wrap_q[k]), 64'(v.wraps[k]));
                if (k > 0) check($sformatf("row%0d_dwell%0d", r, k), 64'(rec_dwell_q[k]), 64'(v.dwell_exp));
            end
        end
        run = 1'b0;
    endtask

`ifdef SWEEP_PINGPONG_EN
    localparam int NV = 3;
`else
    localparam int NV = 6;
`endif
    vec_t vecs[NV];

    initial begin
        int n;
        int c;
`ifdef SWEEP_PINGPONG_EN
        vecs[0] = mk(100, 40, 200, 3, 3, 6'b100000, 100, 140, 180, 140, 100, 140);
        vecs[1] = mk(S_OVF, 20, 48'hFFFF_FFFF_FFFF, 1, 1, 6'b101000,
                     S_OVF, S_OVF + 20, S_OVF, S_OVF + 20, S_OVF, S_OVF + 20);
        vecs[2] = mk(500, 0, 1000, 0, 1, 6'b000000, 500, 500, 500, 500, 500, 500);
`else
        vecs[0] = mk(100, 40, 200, 3, 3, 6'b001000, 100, 140, 180, 100, 140, 180);
        vecs[1] = mk(S_OVF, 20, 48'hFFFF_FFFF_FFFF, 1, 1, 6'b010100,
                     S_OVF, S_OVF + 20, S_OVF, S_OVF + 20, S_OVF, S_OVF + 20);
        vecs[2] = mk(500, 0, 1000, 0, 1, 6'b000000, 500, 500, 500, 500, 500, 500);
        vecs[3] = mk(300, 10, 200, 2, 2, 6'b111110, 300, 300, 300, 300, 300, 300);
        vecs[4] = mk(77, 5, 77, 2, 2, 6'b111110, 77, 77, 77, 77, 77, 77);
        vecs[5] = mk(0, 50, 100, 4, 4, 6'b001000, 0, 50, 100, 0, 50, 100);
`endif

        // Reset state
        hold_reset();
        check("rst_ftw", 64'(ftw), 64'(RESET_FTW));
        check("rst_valid", 64'(ftw_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // Static mode: one transfer, then a start_ftw change gives exactly one more
        run       = 1'b0;
        start_ftw = FTW_1MHZ;
        ftw_ready = 1'b1;
        release_reset();
        tick(20);
        check("static_count1", 64'(rec_ftw_q.size()), 64'd1);
        if (rec_ftw_q.size() > 0) check("static_word1", 64'(rec_ftw_q[0]), 64'(FTW_1MHZ));
        check("static_idle", 64'(busy), 64'd0);
        start_ftw = FTW_5MHZ;
        tick(1);
        check("lat_valid_c1", 64'(ftw_valid), 64'd0);
        check("lat_busy_c1", 64'(busy), 64'd1);
        tick(1);
        check("lat_valid_c2", 64'(ftw_valid), 64'd1);
        check("lat_ftw_c2", 64'(ftw), 64'(FTW_5MHZ));
        tick(20);
        check("static_count2", 64'(rec_ftw_q.size()), 64'd2);
        if (rec_ftw_q.size() > 1) check("static_word2", 64'(rec_ftw_q[1]), 64'(FTW_5MHZ));

        // Back-pressure: word and valid held while ready is low
        ftw_ready = 1'b0;
        start_ftw = 48'd12345;
        c = 0;
        while (!ftw_valid && c < 20) begin
            tick(1);
            c++;
        end
        check("bp_valid_up", 64'(ftw_valid), 64'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!ftw_valid || ftw !== 48'd12345) n++;
        end
        check("bp_stable_violations", 64'(n), 64'd0);
        ftw_ready = 1'b1;
        tick(1);
        check("bp_valid_after", 64'(ftw_valid), 64'd0);
        check("bp_count", 64'(rec_ftw_q.size()), 64'd3);
        if (rec_ftw_q.size() > 2) check("bp_word", 64'(rec_ftw_q[2]), 64'd12345);

        // Sweep tables
        for (int r = 0; r < NV; r++) run_row(vecs[r], r);

        // Restart while a word is offered and stalled, then step_req/restart in DWELL
        hold_reset();
        start_ftw = 100;
        step_ftw  = 40;
        stop_ftw  = 200;
        dwell_cyc = 3;
        ftw_ready = 1'b1;
        run       = 1'b1;
        release_reset();
        wait_recs(2, 100);
        ftw_ready = 1'b0;
        c = 0;
        while (!ftw_valid && c < 20) begin
            tick(1);
            c++;
        end
        check("rs_offer_ftw", 64'(ftw), 64'd180);
        pulse(1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (!ftw_valid || ftw !== 48'd180) n++;
            tick(1);
        end
        check("rs_hold_violations", 64'(n), 64'd0);
        dwell_cyc = 50;
        ftw_ready = 1'b1;
        wait_recs(4, 40);
        exp_q = '{48'd100, 48'd140, 48'd180, 48'd100};
        for (int k = 0; k < 4; k++) begin
            if (k < rec_ftw_q.size()) check($sformatf("rs_word%0d", k), 64'(rec_ftw_q[k]), 64'(exp_q[k]));
        end
        if (rec_dwell_q.size() > 3) check("rs_no_dwell", 64'(rec_dwell_q[3]), 64'd0);
        tick(5);
        pulse(1'b0, 1'b1);
        wait_recs(5, 40);
        if (rec_ftw_q.size() > 4) begin
            check("step_word", 64'(rec_ftw_q[4]), 64'd140);
            check("step_dwell", 64'(rec_dwell_q[4]), 64'd6);
        end
        tick(3);
        pulse(1'b1, 1'b1);
        wait_recs(6, 40);
        if (rec_ftw_q.size() > 5) begin
            check("both_word", 64'(rec_ftw_q[5]), 64'd100);
            check("both_wrap", 64'(rec_wrap_q[5]), 64'd0);
        end
        tick(2);
        pulse(1'b1, 1'b0);
        wait_recs(7, 40);
        if (rec_ftw_q.size() > 6) begin
            check("dwell_rs_word", 64'(rec_ftw_q[6]), 64'd100);
            check("dwell_rs_wrap", 64'(rec_wrap_q[6]), 64'd0);
        end

        // Asynchronous reset in the middle of a dwell
        tick(3);
        check("pre_rst_state", 64'(dbg_state), 64'(DWELL));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ftw", 64'(ftw), 64'(RESET_FTW));
        check("arst_valid", 64'(ftw_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wrap", 64'(wrap), 64'd0);
        check("arst_state", 64'(dbg_state), 64'(IDLE));
        run = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
